// File: rtl/jk_pkg.sv
// Shared defaults for the JK-flip-flop modulo counter.
package jk_pkg;
  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_MODULO = 10;
endpackage

// File: rtl/jk_excite.sv
// One bit of JK excitation in toggle form: J and K are 1 only when the bit must flip.
// Purely combinational, no latency, no flow control.
module jk_excite (
  input  logic q_bit,
  input  logic nxt_bit,
  output logic j_bit,
  output logic k_bit
);
  logic toggle;

  assign toggle = q_bit ^ nxt_bit;
  assign j_bit  = toggle;
  assign k_bit  = toggle;
endmodule

// File: rtl/jk_counter.sv
// Up/down modulo counter built from JK excitation; load/enable/reset with terminal-count flags.
// q updates on the edge that samples its inputs; wrap/load_err are one-cycle registered pulses; no backpressure.
module jk_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned MODULO = DEF_MODULO
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);
  // MODULO may equal 2**WIDTH, so the range check needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] excite_tgt;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             load_ok, at_top, at_zero;

  assign load_ok = {1'b0, load_value} < MOD_EXT;
  assign at_top  = (cnt_q == TOP);
  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_ok ? load_value : '0;
    end else if (enable) begin
      if (up_down) cnt_d = at_top  ? '0  : cnt_q + WIDTH'(1);
      else         cnt_d = at_zero ? TOP : cnt_q - WIDTH'(1);
    end
  end

  always_comb begin
    tc         = enable & ~load & ((up_down & at_top) | (~up_down & at_zero));
    wrap_d     = ~reset & tc;
    load_err_d = ~reset & load & ~load_ok;
    // Targeting the current state during reset keeps J/K at zero; reset itself clears the register.
    excite_tgt = reset ? cnt_q : cnt_d;
  end

  for (genvar b = 0; b < int'(WIDTH); b++) begin : g_excite
    jk_excite u_excite (
      .q_bit   (cnt_q[b]),
      .nxt_bit (excite_tgt[b]),
      .j_bit   (j[b]),
      .k_bit   (k[b])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_q ^ (j & k);
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = cnt_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_jk_counter.sv
// Directed bench for jk_counter (WIDTH=4, MODULO=10) with a per-cycle reference model.
module tb_jk_counter;
  localparam int MOD = 10;

  logic       clock;
  logic       reset, enable, up_down, load;
  logic [3:0] load_value;
  logic [3:0] q, j, k;
  logic       tc, wrap, load_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int mq;
  bit mvalid = 0;
  bit mwrap, mlerr;

  jk_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .q          (q),
    .j          (j),
    .k          (k),
    .tc         (tc),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int m_next(input int qv);
    if (reset)                     return 0;
    if (load)                      return (int'(load_value) < MOD) ? int'(load_value) : 0;
    if (enable && up_down)         return (qv + 1) % MOD;
    if (enable && !up_down)        return (qv + MOD - 1) % MOD;
    return qv;
  endfunction

  function automatic bit m_tc(input int qv);
    return enable && !load && ((up_down && qv == MOD - 1) || (!up_down && qv == 0));
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mq = 0; mwrap = 0; mlerr = 0; mvalid = 1;
    end else if (mvalid) begin
      mwrap = m_tc(mq);
      mlerr = load && (int'(load_value) >= MOD);
      mq    = m_next(mq);
    end
  end

  always @(negedge clock) begin
    int nx;
    int ex;
    #2;
    if (mvalid) begin
      nx = m_next(mq);
      ex = reset ? 0 : (mq ^ nx);
      check("m_q", q, mq);
      check("m_j", j, ex);
      check("m_k", k, ex);
      check("m_tc", tc, m_tc(mq));
      check("m_wrap", wrap, mwrap);
      check("m_load_err", load_err, mlerr);
    end
  end

  task automatic apply(input logic r, input logic en, input logic ud, input logic ld,
                       input logic [3:0] lv);
    @(negedge clock);
    reset = r; enable = en; up_down = ud; load = ld; load_value = lv;
    #2;
  endtask

  int up_q [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int dn_q [4]  = '{3, 2, 1, 0};
  int sw_q [4]  = '{4, 5, 4, 3};
  bit sw_ud [4] = '{1, 0, 0, 1};

  initial begin
    reset = 1; enable = 0; up_down = 1; load = 0; load_value = '0;

    // reset state
    apply(1, 0, 1, 0, 0);
    apply(1, 1, 1, 1, 5);
    check("rst_q", q, 0);
    check("rst_j", j, 0);
    check("rst_k", k, 0);
    check("rst_wrap", wrap, 0);
    check("rst_load_err", load_err, 0);

    // count up through the wrap
    for (int i = 0; i < 12; i++) begin
      apply(0, 1, 1, 0, 0);
      check("up_q", q, up_q[i]);
      check("up_tc", tc, (i == 9) ? 1 : 0);
      check("up_wrap", wrap, (i == 10) ? 1 : 0);
    end
    apply(0, 0, 1, 0, 0);
    check("up_end_q", q, 2);
    check("up_end_wrap", wrap, 0);

    // load 3 then count down past zero
    apply(0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 0, 0);
      check("dn_q", q, dn_q[i]);
      check("dn_tc", tc, (i == 3) ? 1 : 0);
    end
    check("dn_j_0to9", j, 4'b1001);
    check("dn_k_0to9", k, 4'b1001);
    apply(0, 0, 0, 0, 0);
    check("dn_end_q", q, 9);
    check("dn_end_wrap", wrap, 1);

    // out-of-range loads
    apply(0, 0, 0, 1, 12);
    apply(0, 0, 0, 1, 7);
    check("lerr12_q", q, 0);
    check("lerr12_flag", load_err, 1);
    apply(0, 0, 0, 0, 0);
    check("load7_q", q, 7);
    check("load7_flag", load_err, 0);
    apply(0, 0, 0, 1, 10);
    apply(0, 0, 0, 1, 9);
    check("lerr10_q", q, 0);
    check("lerr10_flag", load_err, 1);
    apply(0, 0, 0, 0, 0);
    check("load9_q", q, 9);
    check("load9_flag", load_err, 0);

    // load beats enable at terminal count
    apply(0, 1, 1, 1, 5);
    check("ldwin_q", q, 9);
    check("ldwin_tc", tc, 0);
    apply(0, 0, 1, 0, 0);
    check("ldwin_q_after", q, 5);
    check("ldwin_wrap", wrap, 0);

    // reset mid-count overrides load and enable
    apply(0, 0, 0, 1, 4);
    apply(0, 1, 1, 0, 0);
    check("pre_rst_q4", q, 4);
    apply(0, 1, 1, 0, 0);
    check("pre_rst_q5", q, 5);
    apply(1, 1, 1, 1, 3);
    check("midrst_q6", q, 6);
    check("midrst_j", j, 0);
    check("midrst_k", k, 0);
    apply(0, 1, 1, 0, 0);
    check("post_rst_q0", q, 0);
    apply(0, 0, 1, 0, 0);
    check("post_rst_q1", q, 1);

    // hold with enable low
    apply(0, 0, 0, 1, 4);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, i[0], 0, 0);
      check("hold_q", q, 4);
      check("hold_j", j, 0);
      check("hold_tc", tc, 0);
    end

    // direction changes every cycle with no dead cycle
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, sw_ud[i], 0, 0);
      check("sw_q", q, sw_q[i]);
    end
    apply(0, 0, 1, 0, 0);
    check("sw_end_q", q, 4);

    apply(0, 0, 1, 0, 0);
    apply(0, 0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_counter.md
JK_COUNTER -- requirements
Module: jk_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter/excitation width in bits.
REQ-002 Parameter MODULO, default 10, count range 0..MODULO-1; legal range 2 <= MODULO <= 2**WIDTH.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 enable  input  1  count enable; when low, the counter holds.
REQ-006 up_down  input  1  direction select: 1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 load_value  input  WIDTH  value to load when load is high.
REQ-009 q  output  WIDTH  registered count state.
REQ-010 j  output  WIDTH  per-bit J excitation for the current cycle, combinational from q and the inputs.
REQ-011 k  output  WIDTH  per-bit K excitation for the current cycle, combinational from q and the inputs.
REQ-012 tc  output  1  terminal count, combinational.
REQ-013 wrap  output  1  registered one-cycle pulse after a wrap-around.
REQ-014 load_err  output  1  registered one-cycle pulse after an out-of-range load.

Function
REQ-015 Next state nxt is chosen by strict priority: reset, then load, then enable; otherwise nxt = q.
REQ-016 Load with load_value < MODULO: nxt = load_value.
REQ-017 Load with load_value >= MODULO: nxt = 0, and load_err is 1 in the following cycle.
REQ-018 enable=1, up_down=1: nxt = q+1, except q = MODULO-1, where nxt = 0.
REQ-019 enable=1, up_down=0: nxt = q-1, except q = 0, where nxt = MODULO-1.
REQ-020 Excitation uses toggle form: j[i] = k[i] = q[i] XOR nxt[i], giving 00 (hold) or 11 (toggle), never 10 or 01.
REQ-021 State update is q <= q XOR (j AND k), which must equal nxt every cycle.
REQ-022 tc = enable AND NOT load AND ((up_down AND q == MODULO-1) OR (NOT up_down AND q == 0)).
REQ-023 wrap is 1 in the cycle after a cycle in which tc = 1; otherwise wrap is 0.
REQ-024 When load and enable are both high, load wins; tc = 0 and no wrap pulse follows.
REQ-025 up_down may change on any cycle and takes effect on the next edge; no dead cycle.
REQ-026 Latency: q reflects the inputs sampled at an edge immediately after that edge, with zero added cycles.
REQ-027 All arithmetic is WIDTH bits, unsigned, with no intermediate overflow beyond the explicit wraps above.

Reset
REQ-028 While reset is high at an edge: q = 0, wrap = 0, load_err = 0, and load/enable are ignored.
REQ-029 j and k are forced to 0 during any cycle in which reset is high.
REQ-030 Reset asserted mid-count takes effect at the next edge regardless of load/enable; counting resumes from 0 on the first edge with reset low.
REQ-031 No state depends on simulation initial values.

Structure
REQ-032 Shared package jk_pkg holds the default WIDTH and MODULO constants.
REQ-033 Per-bit excitation is built in one sub-module, jk_excite: inputs q_bit and nxt_bit, outputs j_bit and k_bit; it is instantiated WIDTH times.
REQ-034 Next-state selection, tc, and the registered outputs live in jk_counter.

Verification (WIDTH=4, MODULO=10)
REQ-035 Reset, then enable=1, up_down=1 for 12 edges -> q = 1..9,0,1,2; tc=1 while q=9; wrap=1 in the cycle after q=9.
REQ-036 Load 3, then count down for 4 edges -> q = 3,2,1,0,9; tc=1 at q=0; j=k=4'b1001 on the 0->9 edge.
REQ-037 Load 12 (out of range) -> q=0 and load_err=1 for exactly one cycle; load 7 -> q=7 and load_err=0.
REQ-038 q=9, up, load=1 with load_value=5, enable=1 -> q=5; tc=0; no wrap pulse.
REQ-039 Count to 6, then assert reset with enable=1 and load=1 -> q=0; j=k=0 during reset; counting resumes 0->1 after release.
REQ-040 enable=0 for 5 edges at q=4 -> q stays 4; j=k=0; tc=0.
